// File: rtl/sys1_pkg.sv
// Shared FSM state encoding and HPS download stream selectors for the ROM loader.
package sys1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_CFG = 8'd1;
    localparam logic [7:0] IDX_DSW = 8'd254;

endpackage

// File: rtl/sys1_rom_loader.sv
// HPS ioctl download sink: ROM write port, SYSMODE/DSW config capture, game-core reset sequencing.
// Latency: ROM writes and config updates appear one clk after the ioctl_wr strobe.
// No backpressure: every strobe is consumed on its cycle, out-of-range ROM bytes are dropped and flagged.
module sys1_rom_loader
    import sys1_pkg::*;
#(
    parameter logic [24:0] ROM_BYTES = 25'd262144,
    parameter int          POST_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        rom_we,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [31:0] sysmode,
    output logic [15:0] dsw,
    output logic        core_rst,
    output logic        load_done,
    output logic        size_err,
    output logic        overflow
);

    localparam int             CW        = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
    localparam logic [CW-1:0]  HOLD_INIT = CW'(POST_HOLD - 1);

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  hold_cnt;
    logic [CW-1:0]  hold_cnt_n;
    logic           dl_q;
    logic           rom_start;
    logic           rom_hit;
    logic           rom_acc;
    logic           rom_oob;
    logic           enter_load;
    logic           leave_load;
    logic           enter_ready;
    logic [24:0]    byte_count;
    logic [24:0]    byte_count_nx;

    // Survive reset so an OSD reset keeps DIP settings and skips re-download.
    logic [31:0]    sysmode_q  = 32'd0;
    logic [15:0]    dsw_q      = 16'd0;
    logic           rom_valid  = 1'b0;
    logic           size_err_q = 1'b0;
    logic           overflow_q = 1'b0;

    assign rom_start = ioctl_download && !dl_q && (ioctl_index == IDX_ROM);
    assign rom_hit   = ioctl_wr && (ioctl_index == IDX_ROM) && (state == ST_LOAD);
    assign rom_acc   = rom_hit && (ioctl_addr < ROM_BYTES);
    assign rom_oob   = rom_hit && (ioctl_addr >= ROM_BYTES);

    assign enter_load  = !reset && (state != ST_LOAD) && (state_n == ST_LOAD);
    assign leave_load  = !reset && (state == ST_LOAD) && (state_n == ST_HOLD);
    assign enter_ready = !reset && (state == ST_HOLD) && (state_n == ST_READY);

    // Includes a byte accepted on the LOAD->HOLD cycle in the size check.
    assign byte_count_nx = (rom_acc && (byte_count != '1)) ? byte_count + 25'd1 : byte_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= rom_valid ? ST_HOLD : ST_IDLE;
            hold_cnt <= HOLD_INIT;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        case (state)
            ST_IDLE, ST_READY: begin
                if (rom_start) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    state_n    = ST_HOLD;
                    hold_cnt_n = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = ST_READY;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Edge detector is deliberately not reset: a reset mid-download must not look like a new start.
    always_ff @(posedge clk) begin
        dl_q <= ioctl_download;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_we     <= 1'b0;
            rom_addr   <= 25'd0;
            rom_data   <= 8'd0;
            byte_count <= 25'd0;
        end else begin
            rom_we <= rom_acc;
            if (rom_acc) begin
                rom_addr <= ioctl_addr;
                rom_data <= ioctl_dout;
            end
            if (enter_load) begin
                byte_count <= 25'd0;
            end else begin
                byte_count <= byte_count_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_load) begin
            rom_valid  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (enter_ready) begin
                rom_valid <= 1'b1;
            end
            if (rom_oob && !reset) begin
                overflow_q <= 1'b1;
            end
        end
        if (leave_load) begin
            size_err_q <= (byte_count_nx != ROM_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (ioctl_wr && (ioctl_index == IDX_CFG) && (ioctl_addr[24:2] == 23'd0)) begin
            sysmode_q[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_dout;
        end
        if (ioctl_wr && (ioctl_index == IDX_DSW) && (ioctl_addr[24:1] == 24'd0)) begin
            dsw_q[{ioctl_addr[0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    assign sysmode   = sysmode_q;
    assign dsw       = dsw_q;
    assign size_err  = size_err_q;
    assign overflow  = overflow_q;
    assign core_rst  = reset || (state != ST_READY);
    assign load_done = (state == ST_READY);

endmodule

// File: tb/tb_sys1_rom_loader.sv
// Directed bench for sys1_rom_loader: ROM writes are scoreboarded against a queue of expected (addr, data, cycle).
module tb_sys1_rom_loader;
    import sys1_pkg::*;

    localparam logic [24:0] RB = 25'd128;
    localparam int          PH = 4;

    logic        clk;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] sysmode;
    logic [15:0] dsw;
    logic        core_rst;
    logic        load_done;
    logic        size_err;
    logic        overflow;

    sys1_rom_loader #(.ROM_BYTES(RB), .POST_HOLD(PH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .sysmode        (sysmode),
        .dsw            (dsw),
        .core_rst       (core_rst),
        .load_done      (load_done),
        .size_err       (size_err),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] a;
        logic [7:0]  d;
        int          c;
    } exp_t;

    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data, input bit push);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        if (push) q.push_back('{addr, data, cyc + 1});
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Number of edges until core_rst drops, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (core_rst && n < 60) begin
            tick();
            n++;
        end
    endtask

    // n in-range bytes at addr 0..n-1; optionally a final out-of-range byte at addr RB.
    // The last strobe coincides with download falling, so it lands on the LOAD->HOLD edge.
    task automatic rom_download(input int n, input bit oob);
        ioctl_index    = IDX_ROM;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == n - 1 && !oob) ioctl_download = 1'b0;
            strobe(IDX_ROM, 25'(i), 8'(i), 1'b1);
        end
        if (oob) begin
            ioctl_download = 1'b0;
            strobe(IDX_ROM, RB, 8'h99, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            check("we_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(e.a));
                check("rom_data", 32'(rom_data), 32'(e.d));
                check("we_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        int n;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        tick();
        tick();
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_data", 32'(rom_data), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_sysmode", sysmode, 32'd0);
        check("rst_dsw", 32'(dsw), 32'd0);
        check("rst_size_err", 32'(size_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_core_rst", 32'(core_rst), 32'd1);
        check("idle_load_done", 32'(load_done), 32'd0);

        // Config download in IDLE, with stray out-of-range strobes that must be ignored.
        ioctl_index    = IDX_CFG;
        ioctl_download = 1'b1;
        tick();
        strobe(IDX_CFG, 25'd0, 8'h35, 1'b0);
        strobe(IDX_CFG, 25'd1, 8'h01, 1'b0);
        strobe(IDX_CFG, 25'd2, 8'hAA, 1'b0);
        strobe(IDX_CFG, 25'd3, 8'h55, 1'b0);
        strobe(IDX_CFG, 25'd4, 8'hEE, 1'b0);
        ioctl_download = 1'b0;
        tick();
        ioctl_index    = IDX_DSW;
        ioctl_download = 1'b1;
        tick();
        strobe(IDX_DSW, 25'd0, 8'hFE, 1'b0);
        strobe(IDX_DSW, 25'd1, 8'h7F, 1'b0);
        strobe(IDX_DSW, 25'd2, 8'h00, 1'b0);
        ioctl_download = 1'b0;
        tick();
        check("cfg_sysmode", sysmode, 32'h55AA0135);
        check("cfg_dsw", 32'(dsw), 32'h7FFE);
        check("cfg_state_core_rst", 32'(core_rst), 32'd1);
        check("cfg_state_load_done", 32'(load_done), 32'd0);

        // ROM strobe with download low in IDLE: must not write or count.
        strobe(IDX_ROM, 25'd5, 8'h5A, 1'b0);
        tick();

        rom_download(int'(RB), 1'b0);
        wait_ready(n);
        check("full_hold_cycles", 32'(n), 32'(PH));
        check("full_load_done", 32'(load_done), 32'd1);
        check("full_size_err", 32'(size_err), 32'd0);
        check("full_overflow", 32'(overflow), 32'd0);
        check("full_q_empty", 32'(q.size()), 32'd0);

        // DSW update while READY must leave the FSM alone.
        ioctl_index    = IDX_DSW;
        ioctl_download = 1'b1;
        tick();
        strobe(IDX_DSW, 25'd0, 8'h12, 1'b0);
        ioctl_download = 1'b0;
        tick();
        check("ready_dsw", 32'(dsw), 32'h7F12);
        check("ready_load_done", 32'(load_done), 32'd1);

        // OSD reset from READY: high for the reset cycle plus PH hold cycles.
        reset = 1'b1;
        #1;
        check("osd_core_rst_in_reset", 32'(core_rst), 32'd1);
        tick();
        reset = 1'b0;
        wait_ready(n);
        check("osd_hold_cycles", 32'(n), 32'(PH));
        check("osd_load_done", 32'(load_done), 32'd1);
        check("osd_sysmode_kept", sysmode, 32'h55AA0135);
        check("osd_dsw_kept", 32'(dsw), 32'h7F12);

        // Short download plus one out-of-range byte.
        rom_download(int'(RB) - 1, 1'b1);
        wait_ready(n);
        check("oob_hold_cycles", 32'(n), 32'(PH));
        check("oob_overflow", 32'(overflow), 32'd1);
        check("oob_size_err", 32'(size_err), 32'd1);
        check("oob_q_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of a load.
        ioctl_index    = IDX_ROM;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) strobe(IDX_ROM, 25'(i), 8'(i ^ 8'h3C), 1'b1);
        check("mid_overflow_cleared", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        strobe(IDX_ROM, 25'd7, 8'h77, 1'b0);
        repeat (10) tick();
        check("mid_core_rst", 32'(core_rst), 32'd1);
        check("mid_load_done", 32'(load_done), 32'd0);
        ioctl_download = 1'b0;
        repeat (5) tick();
        check("mid_idle_core_rst", 32'(core_rst), 32'd1);
        strobe(IDX_ROM, 25'd3, 8'h33, 1'b0);
        repeat (PH + 3) tick();
        check("mid_still_idle", 32'(core_rst), 32'd1);

        rom_download(int'(RB), 1'b0);
        wait_ready(n);
        check("reload_hold_cycles", 32'(n), 32'(PH));
        check("reload_load_done", 32'(load_done), 32'd1);
        check("reload_size_err", 32'(size_err), 32'd0);
        tick();
        check("end_q_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
